ifm_axis_out: RTL and testbench
===============================

IFM_AXIS_OUT -- requirements
Module: ifm_axis_out

Interface
REQ-001 C_LEN_W, 16, width of the per-frame byte-length word.
REQ-002 C_STAT_W, 32, width of the statistics counters.
REQ-003 sys_clk  in  1  clock; all logic is on its rising edge.
REQ-004 rx_reset  in  1  asynchronous, active-high reset.
REQ-005 good_fifo_rdata  in  73  first-word-fall-through (FWFT) head word: [63:0] data, [71:64] byte keep (LSB-contiguous), [72] end of frame (EOF).
REQ-006 good_fifo_empty  in  1  high when the head word is invalid.
REQ-007 good_fifo_rden  out  1  pop the head word; combinational.
REQ-008 m_axis_tdata  out  64  AXI4-Stream data.
REQ-009 m_axis_tkeep  out  8  AXI4-Stream byte enables.
REQ-010 m_axis_tlast  out  1  AXI4-Stream end of frame.
REQ-011 m_axis_tvalid  out  1  AXI4-Stream valid.
REQ-012 m_axis_tready  in  1  AXI4-Stream ready.
REQ-013 len_fifo_wdata  out  C_LEN_W  byte length of the completed frame.
REQ-014 len_fifo_wren  out  1  one-cycle write strobe for the length FIFO.
REQ-015 len_fifo_full  in  1  length FIFO cannot accept a write.
REQ-016 stat_frames  out  C_STAT_W  count of frames sent.
REQ-017 stat_bytes  out  C_STAT_W  count of bytes sent.

Function
REQ-018 The block SHALL hold a 2-entry skid buffer (occupancy 0..2) between the good FIFO and the AXI4-Stream port; the stream port presents the oldest entry.
REQ-019 good_fifo_rden SHALL equal: good_fifo_empty low AND (occupancy < 2 OR a beat is accepted this cycle).
REQ-020 Latency: a word popped in cycle t with occupancy 0 SHALL appear on m_axis_* with tvalid high in cycle t+1.
REQ-021 Simultaneous pop and accept SHALL leave occupancy unchanged, with no data loss and no duplication.
REQ-022 A beat is accepted when tvalid AND tready are high; tdata, tkeep and tlast SHALL remain stable while tvalid is high and tready is low.
REQ-023 m_axis_tvalid SHALL be high whenever occupancy > 0, except when the head entry has EOF set and len_fifo_full is high; in that case tvalid SHALL be low until len_fifo_full falls.
REQ-024 The state machine SHALL have two states:
- S_IDLE: no frame in progress.
- S_BODY: frame in progress.
- S_IDLE -> S_BODY on an accepted non-EOF beat.
- S_BODY -> S_IDLE on an accepted EOF beat.
- An accepted EOF beat in S_IDLE (single-beat frame) SHALL stay in S_IDLE.
REQ-025 The length accumulator SHALL add popcount(tkeep) for each accepted beat, saturating at 2^C_LEN_W-1, and SHALL clear on every accepted EOF beat.
REQ-026 On an accepted EOF beat, the block SHALL, in the next cycle, register len_fifo_wren=1 and len_fifo_wdata=(accumulator+popcount(tkeep)) saturated.
REQ-027 On an accepted EOF beat, stat_frames SHALL increment by 1 in the next cycle.
REQ-028 On every accepted beat, stat_bytes SHALL increase by popcount(tkeep) in the next cycle.
REQ-029 stat_frames and stat_bytes SHALL wrap modulo 2^C_STAT_W.
REQ-030 tkeep on non-EOF beats SHALL be passed through unchanged; no keep-contiguity checking is performed.

Reset
REQ-031 While rx_reset is high:
- occupancy = 0
- state = S_IDLE
- length accumulator = 0
- m_axis_tvalid = 0; m_axis_tdata, tkeep, tlast = 0
- len_fifo_wren = 0; len_fifo_wdata = 0
- stat_frames = 0; stat_bytes = 0
- good_fifo_rden = 0
REQ-032 A reset asserted mid-frame SHALL discard the buffered partial frame; no length word is written for it.

Structure
REQ-033 The 73-bit word field positions (EOF bit 72, keep [71:64], data [63:0]) and the state encodings SHALL live in the shared ifm package, common to the ifm_* stages.
REQ-034 The skid buffer SHALL be a sub-module named ifm_skid2, parameterised by width (73 here).

Verification
REQ-035 Single-beat frame: keep=0x0F, EOF=1, tready=1 -> one beat with tlast=1; len_fifo_wdata=4; stat_frames=1; stat_bytes=4.
REQ-036 Three-beat frame, keeps FF,FF,07, tready held low for 5 cycles mid-frame -> data stable while stalled; no loss; length=19.
REQ-037 Back-to-back frames at full throughput with tready=1 -> tvalid high every cycle after the first; two length writes, values correct.
REQ-038 len_fifo_full=1 when the EOF beat reaches the head -> tvalid low until full clears, then tlast beat sent and length written once.
REQ-039 Frame of 8200 full beats -> length saturates at 0xFFFF; stat_bytes = 65600.
REQ-040 rx_reset pulsed after beat 2 of a 4-beat frame -> all outputs zero; no length write; the next frame is measured correctly.

Source files
------------

// File: rtl/ifm_pkg.sv
// Shared definitions for the ifm_* receive-path stages: good-FIFO word layout,
// frame state encodings and a byte-count helper.
package ifm_pkg;

    // Good-FIFO word layout: {eof, keep[7:0], data[63:0]}
    localparam int C_WORD_W   = 73;
    localparam int C_DATA_LSB = 0;
    localparam int C_DATA_MSB = 63;
    localparam int C_KEEP_LSB = 64;
    localparam int C_KEEP_MSB = 71;
    localparam int C_EOF_BIT  = 72;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BODY = 1'b1
    } frame_state_t;

    // Number of set bits in a byte-keep vector (0..8).
    function automatic logic [3:0] keep_popcount(input logic [7:0] keep);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, keep[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/ifm_skid2.sv
// Two-entry in-order skid buffer. slot0 is always the oldest entry and is
// presented on head. The caller guarantees no push when full unless a pop
// happens in the same cycle, and no pop when empty.
module ifm_skid2 #(
    parameter int W = 73
) (
    input  logic         sys_clk,
    input  logic         rx_reset,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic [1:0]   count
);

    logic [W-1:0] slot0;
    logic [W-1:0] slot1;

    assign head = slot0;

    // Storage and occupancy update; push+pop keeps occupancy and shifts order.
    always_ff @(posedge sys_clk or posedge rx_reset) begin
        if (rx_reset) begin
            slot0 <= '0;
            slot1 <= '0;
            count <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) slot0 <= wdata;
                    else               slot1 <= wdata;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    slot0 <= slot1;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        slot0 <= wdata;
                    end else begin
                        slot0 <= slot1;
                        slot1 <= wdata;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/ifm_axis_out.sv
// Good-FIFO to AXI4-Stream egress stage. Buffers words in a 2-entry skid,
// measures each frame's byte length (pushed to the length FIFO one cycle after
// the EOF beat), and keeps frame/byte statistics. The EOF beat is held back
// while the length FIFO is full so a frame never leaves without its length.
module ifm_axis_out
    import ifm_pkg::*;
#(
    parameter int C_LEN_W  = 16,
    parameter int C_STAT_W = 32
) (
    input  logic                sys_clk,
    input  logic                rx_reset,
    input  logic [72:0]         good_fifo_rdata,
    input  logic                good_fifo_empty,
    output logic                good_fifo_rden,
    output logic [63:0]         m_axis_tdata,
    output logic [7:0]          m_axis_tkeep,
    output logic                m_axis_tlast,
    output logic                m_axis_tvalid,
    input  logic                m_axis_tready,
    output logic [C_LEN_W-1:0]  len_fifo_wdata,
    output logic                len_fifo_wren,
    input  logic                len_fifo_full,
    output logic [C_STAT_W-1:0] stat_frames,
    output logic [C_STAT_W-1:0] stat_bytes
);

    logic [C_WORD_W-1:0] head;
    logic [1:0]          occ;
    logic                head_eof;
    logic [7:0]          head_keep;
    logic [3:0]          beat_bytes;
    logic                accept;
    logic                frame_done;
    frame_state_t        state;
    frame_state_t        state_next;
    logic [C_LEN_W-1:0]  acc;
    logic [C_LEN_W-1:0]  acc_next;
    logic [C_LEN_W-1:0]  len_total;
    logic [C_LEN_W:0]    len_sum;
    logic [C_LEN_W:0]    bytes_ext;

    ifm_skid2 #(.W(C_WORD_W)) u_skid (
        .sys_clk  (sys_clk),
        .rx_reset (rx_reset),
        .push     (good_fifo_rden),
        .wdata    (good_fifo_rdata),
        .pop      (accept),
        .head     (head),
        .count    (occ)
    );

    assign head_eof   = head[C_EOF_BIT];
    assign head_keep  = head[C_KEEP_MSB:C_KEEP_LSB];
    assign beat_bytes = keep_popcount(head_keep);

    assign m_axis_tdata = head[C_DATA_MSB:C_DATA_LSB];
    assign m_axis_tkeep = head_keep;
    assign m_axis_tlast = head_eof;

    // Handshake: a beat moves when tvalid && tready; the head entry does not
    // change while tvalid is high and tready is low. An EOF head is withheld
    // (tvalid low) while the length FIFO cannot take the frame length.
    assign m_axis_tvalid  = (occ != 2'd0) && !(head_eof && len_fifo_full);
    assign accept         = m_axis_tvalid && m_axis_tready;
    assign good_fifo_rden = !rx_reset && !good_fifo_empty &&
                            ((occ < 2'd2) || accept);

    // Frame state register.
    always_ff @(posedge sys_clk or posedge rx_reset) begin
        if (rx_reset) state <= S_IDLE;
        else          state <= state_next;
    end

    // Frame state transitions; a single-beat frame stays in S_IDLE.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (accept && !head_eof) state_next = S_BODY;
            S_BODY:  if (accept && head_eof)  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Length arithmetic: saturating running sum including the current beat.
    always_comb begin
        bytes_ext       = '0;
        bytes_ext[3:0]  = beat_bytes;
        len_sum         = {1'b0, acc} + bytes_ext;
        len_total       = len_sum[C_LEN_W] ? {C_LEN_W{1'b1}} : len_sum[C_LEN_W-1:0];
        frame_done      = accept && head_eof;
        acc_next        = acc;
        if (accept) acc_next = head_eof ? '0 : len_total;
    end

    // Accumulator, length-FIFO write and statistics registers.
    always_ff @(posedge sys_clk or posedge rx_reset) begin
        if (rx_reset) begin
            acc            <= '0;
            len_fifo_wren  <= 1'b0;
            len_fifo_wdata <= '0;
            stat_frames    <= '0;
            stat_bytes     <= '0;
        end else begin
            acc           <= acc_next;
            len_fifo_wren <= frame_done;
            if (frame_done) begin
                len_fifo_wdata <= len_total;
                stat_frames    <= stat_frames + 1'b1;
            end
            if (accept) stat_bytes <= stat_bytes + (C_STAT_W)'(beat_bytes);
        end
    end

endmodule

// File: tb/tb_ifm_axis_out.sv
// Bench for ifm_axis_out: FWFT source queue, beat and length scoreboards,
// directed frame table plus hand-written stall / full / reset sequences.
module tb_ifm_axis_out;

    logic        sys_clk;
    logic        rx_reset;
    logic [72:0] good_fifo_rdata;
    logic        good_fifo_empty;
    logic        good_fifo_rden;
    logic [63:0] m_axis_tdata;
    logic [7:0]  m_axis_tkeep;
    logic        m_axis_tlast;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic [15:0] len_fifo_wdata;
    logic        len_fifo_wren;
    logic        len_fifo_full;
    logic [31:0] stat_frames;
    logic [31:0] stat_bytes;

    ifm_axis_out dut (
        .sys_clk         (sys_clk),
        .rx_reset        (rx_reset),
        .good_fifo_rdata (good_fifo_rdata),
        .good_fifo_empty (good_fifo_empty),
        .good_fifo_rden  (good_fifo_rden),
        .m_axis_tdata    (m_axis_tdata),
        .m_axis_tkeep    (m_axis_tkeep),
        .m_axis_tlast    (m_axis_tlast),
        .m_axis_tvalid   (m_axis_tvalid),
        .m_axis_tready   (m_axis_tready),
        .len_fifo_wdata  (len_fifo_wdata),
        .len_fifo_wren   (len_fifo_wren),
        .len_fifo_full   (len_fifo_full),
        .stat_frames     (stat_frames),
        .stat_bytes      (stat_bytes)
    );

    // ---------------- clock / reset ----------------
    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- bookkeeping ----------------
    int total = 0;
    int bad   = 0;
    int beats_seen = 0;
    int seq = 0;

    logic [72:0] src_q[$];
    logic [72:0] exp_q[$];
    logic [15:0] exp_len_q[$];
    logic        pop_s = 1'b0;
    logic        was_stalled = 1'b0;
    logic [72:0] held_word = '0;

    typedef struct {
        int          nbeats;
        logic [7:0]  last_keep;
        logic [15:0] exp_len;
    } frame_vec_t;

    frame_vec_t vecs[4];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic refresh();
        good_fifo_empty = (src_q.size() == 0);
        good_fifo_rdata = (src_q.size() == 0) ? 73'd0 : src_q[0];
    endtask

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    // ---------------- driver tasks ----------------
    task automatic push_frame(input int nbeats, input logic [7:0] last_keep);
        logic [72:0] w;
        logic [31:0] s;
        for (int i = 0; i < nbeats; i++) begin
            s = seq;
            seq++;
            w[63:0]  = {s, ~s};
            w[71:64] = (i == nbeats - 1) ? last_keep : 8'hFF;
            w[72]    = (i == nbeats - 1);
            src_q.push_back(w);
            exp_q.push_back(w);
        end
        refresh();
    endtask

    task automatic wait_drain(input string name, input int max_cyc);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || exp_len_q.size() != 0) && n < max_cyc) begin
            step();
            n++;
        end
        step();
        step();
        check({name, "_drain"}, exp_q.size() + exp_len_q.size(), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_tvalid"}, m_axis_tvalid, 0);
        check({tag, "_tdata"},  m_axis_tdata, 0);
        check({tag, "_tkeep"},  m_axis_tkeep, 0);
        check({tag, "_tlast"},  m_axis_tlast, 0);
        check({tag, "_wren"},   len_fifo_wren, 0);
        check({tag, "_wdata"},  len_fifo_wdata, 0);
        check({tag, "_frames"}, stat_frames, 0);
        check({tag, "_bytes"},  stat_bytes, 0);
        check({tag, "_rden"},   good_fifo_rden, 0);
    endtask

    // ---------------- FWFT source model ----------------
    always @(negedge sys_clk) pop_s = good_fifo_rden;

    always @(posedge sys_clk) begin
        #1;
        if (pop_s && src_q.size() > 0) void'(src_q.pop_front());
        refresh();
    end

    // ---------------- scoreboard / monitor ----------------
    always @(negedge sys_clk) begin
        logic [72:0] cur;
        logic [72:0] w;
        logic [15:0] l;
        cur = {m_axis_tlast, m_axis_tkeep, m_axis_tdata};
        if (!rx_reset) begin
            if (m_axis_tvalid && m_axis_tready) begin
                if (exp_q.size() == 0) begin
                    check("beat_unexpected", 1, 0);
                end else begin
                    w = exp_q.pop_front();
                    check("beat", cur, w);
                end
                beats_seen++;
            end
            if (len_fifo_wren) begin
                if (exp_len_q.size() == 0) begin
                    check("len_unexpected", len_fifo_wdata, 0);
                end else begin
                    l = exp_len_q.pop_front();
                    check("len", len_fifo_wdata, l);
                end
            end
            if (was_stalled && m_axis_tvalid) check("stall_stable", cur, held_word);
            was_stalled = m_axis_tvalid && !m_axis_tready;
            held_word   = cur;
        end else begin
            was_stalled = 1'b0;
        end
    end

    // ---------------- test sequence ----------------
    initial begin
        int base;
        int n;
        int ncyc;
        logic [72:0] w0;

        vecs[0] = '{nbeats: 1, last_keep: 8'h01, exp_len: 16'd1};
        vecs[1] = '{nbeats: 2, last_keep: 8'h3F, exp_len: 16'd14};
        vecs[2] = '{nbeats: 4, last_keep: 8'h07, exp_len: 16'd27};
        vecs[3] = '{nbeats: 3, last_keep: 8'hFF, exp_len: 16'd24};

        rx_reset      = 1'b1;
        m_axis_tready = 1'b0;
        len_fifo_full = 1'b0;
        src_q.push_back(73'h1_FF_0123456789ABCDEF);
        refresh();
        step();
        step();
        check_reset_outputs("reset");
        src_q.delete();
        refresh();
        step();
        rx_reset = 1'b0;
        step();

        // Single-beat frame, including pop-to-valid latency.
        m_axis_tready = 1'b1;
        exp_len_q.push_back(16'd4);
        push_frame(1, 8'h0F);
        @(negedge sys_clk);
        #1;
        check("single_rden", good_fifo_rden, 1);
        check("single_tvalid_before", m_axis_tvalid, 0);
        @(negedge sys_clk);
        #1;
        check("single_tvalid_latency", m_axis_tvalid, 1);
        check("single_tlast", m_axis_tlast, 1);
        wait_drain("single", 50);
        check("single_frames", stat_frames, 1);
        check("single_bytes", stat_bytes, 4);

        // Three-beat frame stalled while the skid fills.
        m_axis_tready = 1'b0;
        exp_len_q.push_back(16'd19);
        push_frame(3, 8'h07);
        w0 = exp_q[0];
        for (int i = 0; i < 5; i++) step();
        check("stall_rden_full", good_fifo_rden, 0);
        check("stall_tvalid", m_axis_tvalid, 1);
        check("stall_head", {m_axis_tlast, m_axis_tkeep, m_axis_tdata}, w0);
        m_axis_tready = 1'b1;
        wait_drain("stall", 50);
        check("stall_frames", stat_frames, 2);
        check("stall_bytes", stat_bytes, 23);

        // Back-to-back frames from the table at full throughput.
        for (int v = 0; v < 4; v++) begin
            exp_len_q.push_back(vecs[v].exp_len);
            push_frame(vecs[v].nbeats, vecs[v].last_keep);
        end
        base = beats_seen;
        ncyc = 0;
        n = 0;
        while ((beats_seen - base) < 10 && n < 100) begin
            @(negedge sys_clk);
            #1;
            if ((beats_seen - base) >= 2) ncyc++;
            n++;
        end
        check("tput_cycles", ncyc, 9);
        wait_drain("table", 50);
        check("table_frames", stat_frames, 6);
        check("table_bytes", stat_bytes, 89);

        // EOF beat withheld while the length FIFO is full.
        len_fifo_full = 1'b1;
        exp_len_q.push_back(16'd10);
        push_frame(2, 8'h03);
        for (int i = 0; i < 6; i++) step();
        check("full_tvalid", m_axis_tvalid, 0);
        check("full_pending", exp_q.size(), 1);
        check("full_frames", stat_frames, 6);
        check("full_wren", len_fifo_wren, 0);
        len_fifo_full = 1'b0;
        wait_drain("full", 50);
        check("full_frames_after", stat_frames, 7);
        check("full_bytes_after", stat_bytes, 99);

        // Reset after beat 2 of a 4-beat frame.
        push_frame(4, 8'hFF);
        base = beats_seen;
        n = 0;
        while ((beats_seen - base) < 2 && n < 50) begin
            step();
            n++;
        end
        check("midreset_beats", beats_seen - base, 2);
        rx_reset = 1'b1;
        step();
        step();
        check_reset_outputs("midreset");
        src_q.delete();
        exp_q.delete();
        refresh();
        rx_reset = 1'b0;
        for (int i = 0; i < 4; i++) step();
        check("midreset_frames", stat_frames, 0);

        // Very long frame: length saturates, byte counter does not.
        exp_len_q.push_back(16'hFFFF);
        push_frame(8200, 8'hFF);
        wait_drain("long", 9000);
        check("long_frames", stat_frames, 1);
        check("long_bytes", stat_bytes, 65600);

        // Accumulator restarts cleanly after a saturated frame.
        exp_len_q.push_back(16'd5);
        push_frame(1, 8'h1F);
        wait_drain("post_sat", 50);
        check("post_sat_frames", stat_frames, 2);
        check("post_sat_bytes", stat_bytes, 65605);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
